// File: rtl/sap1_control_unit_if.sv
// SAP-1 control unit bus: opcode and step request in, control word, ring state and halt out.
interface sap1_control_unit_if;
   logic [3:0]  IR_OP;
   logic        STEP;
   logic [11:0] CW;
   logic [5:0]  T_STATE;
   logic        HALT;

   modport master (output IR_OP, STEP, input CW, T_STATE, HALT);
   modport slave  (input IR_OP, STEP, output CW, T_STATE, HALT);
endinterface

// File: rtl/sap1_control_unit.sv
// SAP-1 controller: six-state ring counter, opcode decode to a 12-bit control word, halt latch.
// Optional single-step gating is enabled by defining CTRL_STEP_EN.
module sap1_control_unit #(
   parameter int unsigned T_STATES = 6
) (
   input logic               CLK,
   input logic               RST_N,
   sap1_control_unit_if.slave bus
);

   typedef enum logic [T_STATES-1:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } ring_t;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } op_t;

   ring_t       state_q, state_d;
   logic        halt_q, halt_d;
   logic        advance;
   logic [11:0] cw;

`ifdef CTRL_STEP_EN
   logic step_q, step_d;
   logic step_prev_q, step_prev_d;

   // Advance fires one edge after the registered STEP shows a 0->1 transition.
   always_comb begin
      step_d      = bus.STEP;
      step_prev_d = step_q;
      advance     = step_q & ~step_prev_q;
   end
`else
   logic unused_step;
   assign unused_step = bus.STEP;
   assign advance     = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      halt_d  = halt_q;
      if (!halt_q && advance) begin
         if (state_q == T4 && bus.IR_OP == OP_HLT) begin
            halt_d = 1'b1;
         end else begin
            case (state_q)
               T1:      state_d = T2;
               T2:      state_d = T3;
               T3:      state_d = T4;
               T4:      state_d = T5;
               T5:      state_d = T6;
               T6:      state_d = T1;
               default: state_d = T1;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= T1;
         halt_q      <= 1'b0;
`ifdef CTRL_STEP_EN
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         halt_q      <= halt_d;
`ifdef CTRL_STEP_EN
         step_q      <= step_d;
         step_prev_q <= step_prev_d;
`endif
      end
   end

   // Bit order, MSB first: L_PC EN_PC L_MAR EN_MEM L_IR EN_IR L_BR L_OUT EN_AR L_AR /ADD_SUB EN_ULA
   always_comb begin
      cw = '0;
      if (!halt_q) begin
         case (state_q)
            T1: cw = 12'h600;
            T2: cw = 12'h800;
            T3: cw = 12'h180;
            T4: begin
               case (bus.IR_OP)
                  OP_LDA, OP_ADD, OP_SUB: cw = 12'h240;
                  OP_OUT:                 cw = 12'h018;
                  default:                cw = '0;
               endcase
            end
            T5: begin
               case (bus.IR_OP)
                  OP_LDA:         cw = 12'h104;
                  OP_ADD, OP_SUB: cw = 12'h120;
                  default:        cw = '0;
               endcase
            end
            T6: begin
               case (bus.IR_OP)
                  OP_ADD:  cw = 12'h005;
                  OP_SUB:  cw = 12'h007;
                  default: cw = '0;
               endcase
            end
            default: cw = '0;
         endcase
      end
   end

   assign bus.CW      = cw;
   assign bus.T_STATE = state_q;
   assign bus.HALT    = halt_q;

endmodule

// File: tb/tb_sap1_control_unit.sv
// Self-checking bench for sap1_control_unit: behavioural instruction-cycle model plus literal sequences.
module tb_sap1_control_unit;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   sap1_control_unit_if bus_if ();

   sap1_control_unit #(.T_STATES(6)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: step number 1..6, a halt flag, and the opcode table written out from the instruction set.
   int   m_t;
   logic m_halt;
   logic m_s1, m_s2;
   logic m_adv;

`ifdef CTRL_STEP_EN
   assign m_adv = m_s1 && !m_s2;
`else
   assign m_adv = 1'b1;
`endif

   function automatic logic [11:0] exp_cw(input int t, input logic [3:0] op, input logic halted);
      logic [11:0] ex [3];
      if (halted) return 12'h000;
      if (t == 1) return 12'h600;
      if (t == 2) return 12'h800;
      if (t == 3) return 12'h180;
      case (op)
         4'h0:    ex = '{12'h240, 12'h104, 12'h000};
         4'h1:    ex = '{12'h240, 12'h120, 12'h005};
         4'h2:    ex = '{12'h240, 12'h120, 12'h007};
         4'hE:    ex = '{12'h018, 12'h000, 12'h000};
         default: ex = '{12'h000, 12'h000, 12'h000};
      endcase
      return ex[t-4];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t    <= 1;
         m_halt <= 1'b0;
         m_s1   <= 1'b0;
         m_s2   <= 1'b0;
      end else begin
         m_s1 <= bus_if.STEP;
         m_s2 <= m_s1;
         if (m_adv && !m_halt) begin
            if (m_t == 4 && bus_if.IR_OP == 4'hF) m_halt <= 1'b1;
            else m_t <= (m_t == 6) ? 1 : m_t + 1;
         end
      end
   end

   always @(negedge clk) begin
      #2;
      chk("model_cw", bus_if.CW, exp_cw(m_t, bus_if.IR_OP, m_halt));
      chk("model_tstate", {6'b0, bus_if.T_STATE}, {6'b0, 6'(1 << (m_t - 1))});
      chk("model_halt", {11'b0, bus_if.HALT}, {11'b0, m_halt});
      chk("one_bus_source",
          {11'b0, ($countones({bus_if.CW[0], bus_if.CW[3], bus_if.CW[6], bus_if.CW[8], bus_if.CW[10]}) <= 1)},
          12'h001);
   end

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_seq(input string name, input logic [3:0] op, input logic [11:0] e [6]);
      do_reset();
      bus_if.IR_OP = op;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk(name, bus_if.CW, e[i]);
         @(negedge clk);
      end
      #1;
      chk({name, "_wrap"}, {6'b0, bus_if.T_STATE}, 12'h001);
   endtask

   logic [3:0] op_tab [8];

   initial begin
      rst_n        = 1'b0;
      bus_if.IR_OP = 4'h0;
      bus_if.STEP  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_tstate", {6'b0, bus_if.T_STATE}, 12'h001);
      chk("reset_halt", {11'b0, bus_if.HALT}, 12'h000);
      chk("reset_cw", bus_if.CW, 12'h600);
      @(negedge clk);
      rst_n = 1'b1;

`ifndef CTRL_STEP_EN
      run_seq("lda", 4'h0, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h104, 12'h000});
      run_seq("add", 4'h1, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h005});
      run_seq("sub", 4'h2, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h007});
      run_seq("out", 4'hE, '{12'h600, 12'h800, 12'h180, 12'h018, 12'h000, 12'h000});
      run_seq("nop7", 4'h7, '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000});

      do_reset();
      bus_if.IR_OP = 4'hF;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("hlt_fetch", bus_if.CW, (i == 0) ? 12'h600 : (i == 1) ? 12'h800 : (i == 2) ? 12'h180 : 12'h000);
         chk("hlt_pre_halt", {11'b0, bus_if.HALT}, 12'h000);
         @(negedge clk);
      end
      #1;
      chk("hlt_set", {11'b0, bus_if.HALT}, 12'h001);
      for (int i = 0; i < 20; i++) begin
         bus_if.IR_OP = 4'($urandom_range(0, 15));
         #1;
         chk("halted_cw", bus_if.CW, 12'h000);
         chk("halted_tstate", {6'b0, bus_if.T_STATE}, 12'h008);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("hlt_clear_tstate", {6'b0, bus_if.T_STATE}, 12'h001);
      chk("hlt_clear_halt", {11'b0, bus_if.HALT}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;

      do_reset();
      bus_if.IR_OP = 4'h1;
      repeat (4) @(negedge clk);
      #1;
      chk("pre_async_t5", {6'b0, bus_if.T_STATE}, 12'h010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tstate", {6'b0, bus_if.T_STATE}, 12'h001);
      chk("async_rst_cw", bus_if.CW, 12'h600);
      @(negedge clk);
      rst_n = 1'b1;
`else
      do_reset();
      repeat (10) @(negedge clk);
      #1;
      chk("step_idle", {6'b0, bus_if.T_STATE}, 12'h001);
      chk("step_idle_cw", bus_if.CW, 12'h600);
      @(negedge clk);
      bus_if.STEP = 1'b1;
      @(negedge clk);
      bus_if.STEP = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("step_once", {6'b0, bus_if.T_STATE}, 12'h002);
      chk("step_once_cw", bus_if.CW, 12'h800);
      @(negedge clk);
`endif

      op_tab = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h3, 4'h7, 4'h0};
      for (int n = 0; n < 600; n++) begin
         op_tab[7]    = 4'($urandom_range(0, 15));
         bus_if.IR_OP = op_tab[$urandom_range(0, 7)];
         bus_if.STEP  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            #3 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         @(negedge clk);
      end

      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sap1_control_unit.md
# sap1_control_unit

SAP-1 controller that generates the 12-bit control word `CW`. `CW` is consumed by the bus multiplexer and by every load/enable input in the datapath. The block holds a six-state ring counter (T1–T6) and decodes the instruction-register opcode nibble into per-state control words. It also latches a halt condition and, optionally, gates execution with a single-step input.

## Interface
Parameters:
- `T_STATES`, 6, number of ring-counter states; fixed at 6, any other value is unsupported.

Ports:
- `CLK`  input  1  system clock; all state updates on the rising edge.
- `RST_N`  input  1  asynchronous active-low reset; one clock, async reset, active low.
- `IR_OP`  input  4  opcode, the upper nibble of the instruction register.
- `STEP`  input  1  single-step request; used only when `CTRL_STEP_EN` is defined, otherwise ignored.
- `CW`  output  12  control word.
  - Bit order: [0] EN_ULA, [1] /ADD_SUB, [2] L_AR, [3] EN_AR, [4] L_OUT, [5] L_BR, [6] EN_IR, [7] L_IR, [8] EN_MEM, [9] L_MAR, [10] EN_PC, [11] L_PC.
  - L_PC means "PC increment strobe".
- `T_STATE`  output  6  one-hot ring state; bit0 = T1.
- `HALT`  output  1  high once HLT has executed; stays high until reset.

## Operation
- The ring counter advances T1→T2→…→T6→T1, one state per advance. An advance is every clock, or per step when `CTRL_STEP_EN` is defined.
- Fetch states, independent of opcode:
  - T1 = 0x600 (EN_PC, L_MAR)
  - T2 = 0x800 (L_PC)
  - T3 = 0x180 (EN_MEM, L_IR)
- Execute states, T4/T5/T6:
  - LDA 0x0: 0x240 / 0x104 / 0x000.
  - ADD 0x1: 0x240 / 0x120 / 0x005.
  - SUB 0x2: 0x240 / 0x120 / 0x007.
  - OUT 0xE: 0x018 / 0x000 / 0x000.
  - HLT 0xF: 0x000 in T4. At the edge ending T4, the `HALT` register sets and the ring counter freezes in T4.
  - Any other opcode: NOP, 0x000 in T4–T6; the ring continues normally.
- While `HALT`=1, `CW`=0x000 and `T_STATE` holds T4. Only `RST_N` clears this.
- Invariant: at most one of EN_ULA, EN_AR, EN_IR, EN_MEM, EN_PC is high in any cycle. Bus-source priority is therefore never exercised.
- `IR_OP` is sampled only in T4–T6. Its value during T1–T3 has no effect.

## Timing
- `CW` is a combinational decode of the registered ring state, `IR_OP` and `HALT`. It is valid in the same cycle the state is entered, with zero latency, and is consumed at the next rising `CLK`.
- The IR is loaded at the edge ending T3, so T4 decodes the new opcode.
- Each instruction takes 6 cycles. HLT reaches the halted state 4 cycles after entering T1.
- Reset values:
  - `T_STATE` = 6'b000001.
  - `HALT` = 0.
  - `CW` = 0x600.
- Reset asserted mid-instruction: the block returns immediately, asynchronously, to T1 with `HALT`=0. Deassertion takes effect on the next `CLK` edge.

## Configuration
- Macro `CTRL_STEP_EN`.
- Defined:
  - `STEP` is registered and edge-detected.
  - The ring advances exactly once per `STEP` 0→1 transition, on the `CLK` edge after the rising edge is detected.
  - `CW` for the current state stays driven while waiting. Datapath loads still occur on every `CLK` edge, so the datapath must treat waiting cycles idempotently.
  - The edge-detect register resets to 0.
  - `STEP` is assumed synchronous to `CLK`.
- Undefined: the `STEP` port exists but is ignored, and the ring advances every `CLK`.

## Test plan
- Reset: hold `RST_N`=0 -> `T_STATE`=000001, `HALT`=0, `CW`=0x600. Release, then clock 5 cycles -> `CW` sequence 0x800, 0x180, then the opcode-dependent T4–T6 values.
- LDA (`IR_OP`=0x0) -> T1..T6 `CW` = 0x600, 0x800, 0x180, 0x240, 0x104, 0x000; back to T1 on cycle 7.
- SUB (`IR_OP`=0x2) -> T5=0x120, T6=0x007. With ADD (0x1), T6=0x005.
- HLT (`IR_OP`=0xF) -> `HALT`=1 after the edge ending T4. `CW`=0x000 and `T_STATE`=T4 for 20 further cycles. `RST_N` pulse -> T1, `HALT`=0.
- Undefined opcode 0x7 and OUT (0xE): 0x7 -> `CW`=0x000 in T4–T6. 0xE -> T4=0x018. Every cycle of every test checks that at most one EN bit is high.
- Reset asserted asynchronously mid-T5 -> immediate T1. With `CTRL_STEP_EN`: no `STEP` for 10 clocks -> state unchanged. One `STEP` pulse -> exactly one advance.
